branch_compare_unit: RTL and testbench
======================================

Name: branch_compare_unit

Overview:
Iterative operand comparator that produces the eq/gteu/gtes/ltu/lts flags and the cmp_branch qualifier consumed by the conditional-branch control logic. It compares rs1 and rs2 most-significant digit first, DIGIT_W bits per cycle, and terminates at the first differing digit. Results are registered, held stable, and announced with a one-cycle valid pulse. It sits between the register-file read stage and cond_branch_control, and frees the datapath from a full-width single-cycle comparator.

Parameters:
XLEN, 32, operand width in bits
DIGIT_W, 4, bits compared per cycle; must divide XLEN; NDIG = XLEN/DIGIT_W (default 8)

Ports:
clk_w_i  in  1  clock, rising edge
rst_w_i_h  in  1  asynchronous active-high reset
start_w_i_h  in  1  request a compare; sampled only in IDLE
rs1_w_i  in  XLEN  operand A; sampled on the start edge
rs2_w_i  in  XLEN  operand B; sampled on the start edge
branch_w_i_h  in  1  instruction is a conditional branch; sampled on the start edge
busy_w_o_h  out  1  high while in BUSY
valid_w_o_h  out  1  one-cycle pulse; flags below are new
eq_w_o_h  out  1  rs1 == rs2
ltu_w_o_h  out  1  rs1 < rs2, unsigned
gteu_w_o_h  out  1  rs1 >= rs2, unsigned
lts_w_o_h  out  1  rs1 < rs2, signed (two's complement)
gtes_w_o_h  out  1  rs1 >= rs2, signed
cmp_branch_w_o_h  out  1  latched branch_w_i_h, updated with the flags

Behaviour:
- Clocking: one clock, clk_w_i. Reset rst_w_i_h is asynchronous and active-high.
- Reset values: state = IDLE; busy, valid, eq, ltu, lts and cmp_branch = 0; gteu and gtes = 0.
- A reset asserted mid-operation aborts the compare. No valid pulse is produced for the aborted compare.
- States: IDLE and BUSY.
- IDLE with start_w_i_h = 1 at edge E0:
  - Latch rs1, rs2 and branch_w_i_h into internal registers.
  - Set digit index to NDIG-1.
  - Record sign_diff = rs1[XLEN-1] ^ rs2[XLEN-1].
  - Go to BUSY.
- start_w_i_h in BUSY is ignored; it is neither queued nor allowed to corrupt the latched operands.
- BUSY, at each edge, compare digit [idx*DIGIT_W +: DIGIT_W] of the latched operands:
  - Digits differ: the decision is taken with ltu = (a_dig < b_dig) and eq = 0. Go to IDLE.
  - Digits equal and idx == 0: the decision is taken with eq = 1 and ltu = 0. Go to IDLE.
  - Otherwise: decrement idx and stay in BUSY.
- On the decision edge, register all outputs:
  - gteu = ~ltu
  - lts = sign_diff ? latched rs1[XLEN-1] : ltu
  - gtes = ~lts
  - cmp_branch = latched branch
  - valid_w_o_h = 1 for exactly the following cycle.
- Latency: with the first differing digit at position k from the top (k = 1..NDIG; k = NDIG when operands are equal), valid is high in the cycle after edge E0+k.
  - Minimum: 1 cycle after the start edge.
  - Maximum: NDIG cycles after the start edge.
- busy_w_o_h is high from E0 to the decision edge. It is low in the valid cycle.
- A start asserted in the valid cycle is accepted (state is already IDLE). This gives back-to-back operation with no dead cycle.
- Flags hold their last values between decisions, including throughout BUSY. They change only on a decision edge or on reset.
- Invariants after any decision:
  - eq = 1 implies ltu = 0, lts = 0, gteu = 1, gtes = 1.
  - gteu == ~ltu.
  - gtes == ~lts.

Test Plan:
1. Equal operands: rs1 = rs2 = 0x12345678, branch = 1, start pulse → valid exactly 8 cycles after the start edge; eq=1 gteu=1 gtes=1 ltu=0 lts=0 cmp_branch=1; busy high for 8 cycles.
2. Early exit with signed/unsigned disagreement: rs1 = 0xF0000000, rs2 = 0x00000001 → valid 1 cycle after the start edge; eq=0 ltu=0 gteu=1 lts=1 gtes=0.
3. Late exit: rs1 = 5, rs2 = 6, branch = 0 → valid 8 cycles after the start edge; ltu=1 lts=1 gteu=0 gtes=0 eq=0 cmp_branch=0. Then rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFE → valid after 8 cycles; ltu=0 lts=0 gteu=1 gtes=1.
4. Start while busy: start with 1/2; re-pulse start with rs1 = 9, rs2 = 9 two cycles later → ignored; result is ltu=1, a single valid pulse, flags stable until the next decision.
5. Back-to-back: assert start in the valid cycle with new operands 0x80000000/0x7FFFFFFF → accepted; next valid 1 cycle later with ltu=0 lts=1.
6. Reset mid-operation: start with equal operands, assert reset 3 cycles later → all outputs 0 immediately (asynchronous); no valid pulse; a subsequent start operates normally.

Source files
------------

// File: rtl/branch_compare_unit_if.sv
// rtl/branch_compare_unit_if.sv - operand/flag bundle between register read and branch control
interface branch_compare_unit_if #(
  parameter int XLEN = 32
) ();
  logic            start_w_i_h;
  logic [XLEN-1:0] rs1_w_i;
  logic [XLEN-1:0] rs2_w_i;
  logic            branch_w_i_h;
  logic            busy_w_o_h;
  logic            valid_w_o_h;
  logic            eq_w_o_h;
  logic            ltu_w_o_h;
  logic            gteu_w_o_h;
  logic            lts_w_o_h;
  logic            gtes_w_o_h;
  logic            cmp_branch_w_o_h;

  modport master (
    output start_w_i_h, rs1_w_i, rs2_w_i, branch_w_i_h,
    input  busy_w_o_h, valid_w_o_h, eq_w_o_h, ltu_w_o_h,
    input  gteu_w_o_h, lts_w_o_h, gtes_w_o_h, cmp_branch_w_o_h
  );

  modport slave (
    input  start_w_i_h, rs1_w_i, rs2_w_i, branch_w_i_h,
    output busy_w_o_h, valid_w_o_h, eq_w_o_h, ltu_w_o_h,
    output gteu_w_o_h, lts_w_o_h, gtes_w_o_h, cmp_branch_w_o_h
  );
endinterface

// File: rtl/branch_compare_unit.sv
// rtl/branch_compare_unit.sv - digit-serial MSD-first comparator producing branch condition flags
module branch_compare_unit #(
  parameter int XLEN    = 32,
  parameter int DIGIT_W = 4
) (
  input  logic                 clk_w_i,
  input  logic                 rst_w_i_h,
  branch_compare_unit_if.slave bus
);
  localparam int NDIG  = XLEN / DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [XLEN-1:0]  a_q, a_d;
  logic [XLEN-1:0]  b_q, b_d;
  logic             br_q, br_d;
  logic             sd_q, sd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             eq_q, eq_d;
  logic             ltu_q, ltu_d;
  logic             gteu_q, gteu_d;
  logic             lts_q, lts_d;
  logic             gtes_q, gtes_d;
  logic             cmpb_q, cmpb_d;

  logic [DIGIT_W-1:0] dig_a, dig_b;
  logic               dig_lt;

  assign dig_a  = a_q[idx_q*DIGIT_W +: DIGIT_W];
  assign dig_b  = b_q[idx_q*DIGIT_W +: DIGIT_W];
  assign dig_lt = (dig_a < dig_b);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    sd_d    = sd_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    eq_d    = eq_q;
    ltu_d   = ltu_q;
    gteu_d  = gteu_q;
    lts_d   = lts_q;
    gtes_d  = gtes_q;
    cmpb_d  = cmpb_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start_w_i_h) begin
          a_d     = bus.rs1_w_i;
          b_d     = bus.rs2_w_i;
          br_d    = bus.branch_w_i_h;
          sd_d    = bus.rs1_w_i[XLEN-1] ^ bus.rs2_w_i[XLEN-1];
          idx_d   = IDX_W'(NDIG - 1);
          state_d = ST_BUSY;
        end
      end
      default: begin
        // First differing digit decides; equal down to digit 0 means equal operands
        if ((dig_a != dig_b) || (idx_q == '0)) begin
          eq_d    = (dig_a == dig_b);
          ltu_d   = dig_lt;
          gteu_d  = ~dig_lt;
          lts_d   = sd_q ? a_q[XLEN-1] : dig_lt;
          gtes_d  = ~(sd_q ? a_q[XLEN-1] : dig_lt);
          cmpb_d  = br_q;
          valid_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
    if (rst_w_i_h) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      sd_q    <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      eq_q    <= 1'b0;
      ltu_q   <= 1'b0;
      gteu_q  <= 1'b0;
      lts_q   <= 1'b0;
      gtes_q  <= 1'b0;
      cmpb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      sd_q    <= sd_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      eq_q    <= eq_d;
      ltu_q   <= ltu_d;
      gteu_q  <= gteu_d;
      lts_q   <= lts_d;
      gtes_q  <= gtes_d;
      cmpb_q  <= cmpb_d;
    end
  end

  assign bus.busy_w_o_h       = (state_q == ST_BUSY);
  assign bus.valid_w_o_h      = valid_q;
  assign bus.eq_w_o_h         = eq_q;
  assign bus.ltu_w_o_h        = ltu_q;
  assign bus.gteu_w_o_h       = gteu_q;
  assign bus.lts_w_o_h        = lts_q;
  assign bus.gtes_w_o_h       = gtes_q;
  assign bus.cmp_branch_w_o_h = cmpb_q;
endmodule

// File: tb/tb_branch_compare_unit.sv
// tb/tb_branch_compare_unit.sv - self-checking bench for branch_compare_unit
module tb_branch_compare_unit;
  localparam int XLEN    = 32;
  localparam int DIGIT_W = 4;
  localparam int NDIG    = XLEN / DIGIT_W;

  logic clk;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  branch_compare_unit_if #(.XLEN(XLEN)) bus ();

  branch_compare_unit #(.XLEN(XLEN), .DIGIT_W(DIGIT_W)) dut (
    .clk_w_i   (clk),
    .rst_w_i_h (rst),
    .bus       (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: flags from plain arithmetic, latency from position of first differing digit
  logic       m_busy = 1'b0;
  logic       m_valid = 1'b0;
  logic [5:0] m_flags = 6'b0;
  logic [5:0] m_pend = 6'b0;
  int         m_left = 0;

  function automatic int first_diff_pos(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    for (int i = NDIG - 1; i >= 0; i--)
      if (a[i*DIGIT_W +: DIGIT_W] != b[i*DIGIT_W +: DIGIT_W]) return NDIG - i;
    return NDIG;
  endfunction

  function automatic logic [5:0] model_flags(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                             input logic br);
    logic ltu, lts;
    ltu = (a < b);
    lts = ($signed(a) < $signed(b));
    return {(a == b), ltu, ~ltu, lts, ~lts, br};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      m_flags = 6'b0;
      m_left  = 0;
    end else begin
      m_valid = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy  = 1'b0;
          m_valid = 1'b1;
          m_flags = m_pend;
        end
      end else if (bus.start_w_i_h) begin
        m_pend = model_flags(bus.rs1_w_i, bus.rs2_w_i, bus.branch_w_i_h);
        m_left = first_diff_pos(bus.rs1_w_i, bus.rs2_w_i);
        m_busy = 1'b1;
      end
    end
  end

  function automatic logic [5:0] dut_flags();
    return {bus.eq_w_o_h, bus.ltu_w_o_h, bus.gteu_w_o_h, bus.lts_w_o_h,
            bus.gtes_w_o_h, bus.cmp_branch_w_o_h};
  endfunction

  always @(negedge clk) begin
    check("cycle", {24'b0, bus.busy_w_o_h, bus.valid_w_o_h, dut_flags()},
          {24'b0, m_busy, m_valid, m_flags});
  end

  // Start one compare; returns in the valid cycle (posedge+1) when found
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic br, input int exp_lat, input logic [5:0] exp_f,
                        input bit immediate);
    int lat;
    bit found;
    if (!immediate) @(posedge clk);
    #2;
    bus.start_w_i_h  = 1'b1;
    bus.rs1_w_i      = a;
    bus.rs2_w_i      = b;
    bus.branch_w_i_h = br;
    @(posedge clk);
    #3;
    bus.start_w_i_h = 1'b0;
    lat   = 0;
    found = 1'b0;
    while (!found && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.valid_w_o_h) found = 1'b1;
    end
    check({name, "_seen"}, 32'(found), 32'd1);
    check({name, "_lat"}, lat, exp_lat);
    check({name, "_flags"}, {26'b0, dut_flags()}, {26'b0, exp_f});
  endtask

  initial begin
    int vcount;
    bus.start_w_i_h  = 1'b0;
    bus.rs1_w_i      = '0;
    bus.rs2_w_i      = '0;
    bus.branch_w_i_h = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("reset_outs", {24'b0, bus.busy_w_o_h, bus.valid_w_o_h, dut_flags()}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // Flag order: {eq, ltu, gteu, lts, gtes, cmp_branch}
    run_op("equal",    32'h12345678, 32'h12345678, 1'b1, 8, 6'b101011, 1'b0);
    run_op("early",    32'hF0000000, 32'h00000001, 1'b1, 1, 6'b001101, 1'b0);
    run_op("late_lt",  32'h00000005, 32'h00000006, 1'b0, 8, 6'b010100, 1'b0);
    run_op("late_ge",  32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 8, 6'b001011, 1'b0);
    run_op("b2b",      32'h80000000, 32'h7FFFFFFF, 1'b0, 1, 6'b001100, 1'b1);

    // Start while busy must be ignored
    @(posedge clk);
    #2;
    bus.start_w_i_h  = 1'b1;
    bus.rs1_w_i      = 32'd1;
    bus.rs2_w_i      = 32'd2;
    bus.branch_w_i_h = 1'b0;
    @(posedge clk);
    #3 bus.start_w_i_h = 1'b0;
    @(posedge clk);
    #3;
    bus.start_w_i_h = 1'b1;
    bus.rs1_w_i     = 32'd9;
    bus.rs2_w_i     = 32'd9;
    @(posedge clk);
    #3 bus.start_w_i_h = 1'b0;
    vcount = 0;
    repeat (14) begin
      @(posedge clk);
      #1;
      if (bus.valid_w_o_h) begin
        vcount++;
        check("busy_ign_flags", {26'b0, dut_flags()}, {26'b0, 6'b010100});
      end
    end
    check("busy_ign_pulses", vcount, 1);
    check("busy_ign_hold", {26'b0, dut_flags()}, {26'b0, 6'b010100});

    // Reset mid-operation
    @(posedge clk);
    #2;
    bus.start_w_i_h = 1'b1;
    bus.rs1_w_i     = 32'hCAFEF00D;
    bus.rs2_w_i     = 32'hCAFEF00D;
    @(posedge clk);
    #3 bus.start_w_i_h = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst", {24'b0, bus.busy_w_o_h, bus.valid_w_o_h, dut_flags()}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    vcount = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.valid_w_o_h) vcount++;
    end
    check("abort_no_valid", vcount, 0);
    run_op("post_rst", 32'h000000A0, 32'h000000B0, 1'b1, 7, 6'b010101, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
